micro_reg_file: RTL and testbench

//  - General-purpose register file of the micro CPU datapath; sits between decode and ALU.
//  - Single port: one access per instruction, either a read or a write, selected by reg_file_rw.
//  - Accesses are qualified by the CPU state machine and are committed only in EXECUTE1.
//  - Read data is registered and held stable through EXECUTE2 and after, for the ALU and the
//    ALU micro-register.

---
 rtl/micro_reg_file_if.sv | 24 ++
 rtl/micro_reg_file.sv | 60 ++++++
 tb/tb_micro_reg_file.sv | 126 ++++++++++++
 3 files changed

// File: rtl/micro_reg_file_if.sv
// micro_reg_file_if: decode-side access bus of the micro CPU register file
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef REG_SPEC_WIDTH
`define REG_SPEC_WIDTH 3
`endif
`ifndef CPU_STATES
`define CPU_STATES 4
`endif
interface micro_reg_file_if #(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int REG_SPEC_WIDTH = `REG_SPEC_WIDTH,
  parameter int CPU_STATES     = `CPU_STATES
);
  logic [$clog2(CPU_STATES)-1:0] cpu_state;
  logic                          reg_file_en;
  logic                          reg_file_rw;
  logic [REG_SPEC_WIDTH-1:0]     reg_sel;
  logic [DATA_WIDTH-1:0]         reg_wr_data;
  logic [DATA_WIDTH-1:0]         reg_rd_data;
  modport master (output cpu_state, reg_file_en, reg_file_rw, reg_sel, reg_wr_data, input reg_rd_data);
  modport slave  (input cpu_state, reg_file_en, reg_file_rw, reg_sel, reg_wr_data, output reg_rd_data);
endinterface

// File: rtl/micro_reg_file.sv
// micro_reg_file: single-port register file, accesses commit only in EXECUTE1
// MICRO_REG_ZERO_EN: when defined, register 0 is hardwired to zero
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef REG_SPEC_WIDTH
`define REG_SPEC_WIDTH 3
`endif
`ifndef CPU_STATES
`define CPU_STATES 4
`endif
`ifndef EXECUTE1
`define EXECUTE1 2
`endif
`ifndef REG_FILE_WRITE
`define REG_FILE_WRITE 1'b1
`endif
`ifndef REG_FILE_READ
`define REG_FILE_READ 1'b0
`endif
module micro_reg_file #(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int REG_SPEC_WIDTH = `REG_SPEC_WIDTH,
  parameter int NUM_REGS       = 8,
  parameter int CPU_STATES     = `CPU_STATES,
  parameter logic [$clog2(CPU_STATES)-1:0] ST_EXECUTE1 = `EXECUTE1
) (
  input logic              sys_clk,
  input logic              sys_reset,
  micro_reg_file_if.slave  bus
);
`ifdef MICRO_REG_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_commit;
  assign w_commit = bus.reg_file_en && bus.cpu_state == ST_EXECUTE1;
  // Indices past NUM_REGS (or the hardwired zero register) never match, so reads yield 0
  always_comb begin
    w_rd_data = '0;
    for (int i = FIRST; i < NUM_REGS; i++)
      if (bus.reg_sel == i[REG_SPEC_WIDTH-1:0]) w_rd_data = r_regs[i];
  end
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_rd_data <= '0;
    end else if (w_commit) begin
      if (bus.reg_file_rw == `REG_FILE_WRITE) begin
        for (int i = FIRST; i < NUM_REGS; i++)
          if (bus.reg_sel == i[REG_SPEC_WIDTH-1:0]) r_regs[i] <= bus.reg_wr_data;
      end else r_rd_data <= w_rd_data;
    end
  end
  assign bus.reg_rd_data = r_rd_data;
endmodule

// File: tb/tb_micro_reg_file.sv
// tb_micro_reg_file: directed checks of micro_reg_file, plus a 6-register copy for range checks
module tb_micro_reg_file;
  localparam logic [1:0] FETCH = 2'd0, DECODE = 2'd1, EX1 = 2'd2, EX2 = 2'd3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  micro_reg_file_if #(.DATA_WIDTH(8), .REG_SPEC_WIDTH(3), .CPU_STATES(4)) bus ();
  micro_reg_file_if #(.DATA_WIDTH(8), .REG_SPEC_WIDTH(3), .CPU_STATES(4)) bus6 ();
  assign bus6.cpu_state   = bus.cpu_state;
  assign bus6.reg_file_en = bus.reg_file_en;
  assign bus6.reg_file_rw = bus.reg_file_rw;
  assign bus6.reg_sel     = bus.reg_sel;
  assign bus6.reg_wr_data = bus.reg_wr_data;
  micro_reg_file #(.NUM_REGS(8)) dut (.sys_clk(clk), .sys_reset(rst_n), .bus(bus));
  micro_reg_file #(.NUM_REGS(6)) dut6 (.sys_clk(clk), .sys_reset(rst_n), .bus(bus6));
  function automatic logic [7:0] z0(input int sel, input logic [7:0] d);
`ifdef MICRO_REG_ZERO_EN
    return sel == 0 ? 8'h00 : d;
`else
    return d;
`endif
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic [1:0] st, input logic en, input logic rw, input int sel, input logic [7:0] d);
    bus.cpu_state = st;
    bus.reg_file_en = en;
    bus.reg_file_rw = rw;
    bus.reg_sel = sel[2:0];
    bus.reg_wr_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int sel, input logic [7:0] d);
    cyc(EX1, 1'b1, 1'b1, sel, d);
    cyc(EX2, 1'b0, 1'b0, 0, 8'h00);
  endtask
  task automatic rd(input int sel);
    cyc(EX1, 1'b1, 1'b0, sel, 8'hEE);
    bus.cpu_state = EX2;
    bus.reg_file_en = 1'b0;
  endtask
  initial begin
    bus.cpu_state = FETCH;
    bus.reg_file_en = 1'b0;
    bus.reg_file_rw = 1'b0;
    bus.reg_sel = '0;
    bus.reg_wr_data = '0;
    #3;
    chk("reset_no_clock", bus.reg_rd_data, 8'h00);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(i);
      chk($sformatf("reset_reg%0d", i), bus.reg_rd_data, 8'h00);
      @(posedge clk); #1;
    end
    wr(0, 8'hA4);
    rd(0);
    chk("wr_rd_reg0", bus.reg_rd_data, z0(0, 8'hA4));
    @(posedge clk); #1;
    chk("rd_valid_ex2", bus.reg_rd_data, z0(0, 8'hA4));
    cyc(EX2, 1'b1, 1'b1, 3, 8'h55);
    cyc(FETCH, 1'b1, 1'b1, 3, 8'h55);
    cyc(DECODE, 1'b1, 1'b1, 3, 8'h55);
    rd(3);
    chk("gate_state", bus.reg_rd_data, 8'h00);
    @(posedge clk); #1;
    cyc(EX1, 1'b0, 1'b1, 3, 8'h55);
    rd(3);
    chk("gate_en", bus.reg_rd_data, 8'h00);
    @(posedge clk); #1;
    cyc(EX1, 1'b0, 1'b0, 0, 8'h00);
    chk("rd_gate_en", bus.reg_rd_data, 8'h00);
    wr(1, 8'h3C);
    rd(1);
    chk("hold_rd", bus.reg_rd_data, 8'h3C);
    @(posedge clk); #1;
    wr(1, 8'hC3);
    chk("hold_over_wr", bus.reg_rd_data, 8'h3C);
    cyc(FETCH, 1'b1, 1'b0, 0, 8'h00);
    cyc(DECODE, 1'b1, 1'b0, 0, 8'h00);
    cyc(EX2, 1'b1, 1'b0, 0, 8'h00);
    chk("hold_non_ex1", bus.reg_rd_data, 8'h3C);
    rd(1);
    chk("raw_reg1", bus.reg_rd_data, 8'hC3);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) wr(i, 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      rd(i);
      chk($sformatf("all_reg%0d", i), bus.reg_rd_data, z0(i, 8'h10 + 8'(i)));
      chk($sformatf("all6_reg%0d", i), bus6.reg_rd_data, i < 6 ? z0(i, 8'h10 + 8'(i)) : 8'h00);
      @(posedge clk); #1;
    end
    wr(7, 8'hFF);
    rd(7);
    chk("oor_full", bus.reg_rd_data, 8'hFF);
    chk("oor_dropped", bus6.reg_rd_data, 8'h00);
    @(posedge clk); #1;
    wr(5, 8'h81);
    rd(5);
    chk("edge_reg5", bus6.reg_rd_data, 8'h81);
    @(posedge clk); #1;
    rd(2);
    chk("pre_areset", bus.reg_rd_data, 8'h12);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_mid", bus.reg_rd_data, 8'h00);
    chk("areset_mid6", bus6.reg_rd_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(i);
      chk($sformatf("cleared_reg%0d", i), bus.reg_rd_data, 8'h00);
      @(posedge clk); #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
